// File: rtl/shift_pkg.sv
// Shared types and widths for the two-requester shift scheduler.
package shift_pkg;
  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;
  localparam int K_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_e;
endpackage

// File: rtl/shift_step.sv
// Single-step shifter: moves acc by k positions (k <= 8), filling vacated bits.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] acc_i,
  input  logic [K_W-1:0]    k_i,
  input  shift_dir_e        dir_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] next_acc_o
);

  logic [DATA_W-1:0] fill_mask_s;

  // Vacated high bits on a right shift take the fill bit; left always zero-fills.
  always_comb begin
    fill_mask_s = ~({DATA_W{1'b1}} >> k_i);
    if (dir_i == DIR_LEFT) begin
      next_acc_o = acc_i << k_i;
    end else begin
      next_acc_o = (acc_i >> k_i) | ({DATA_W{fill_i}} & fill_mask_s);
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Round-robin two-client scheduler driving an iterative shifter of STEP bits/cycle.
module shift_sched
  import shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] req_data,
  input  logic [1:0][AMT_W-1:0]  req_amt,
  input  logic [1:0]             req_dir,
  input  logic [1:0]             req_arith,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_id,
  output logic                   busy
);

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);
  localparam logic [K_W-1:0]   STEP_K   = K_W'(STEP);

  sched_state_e      state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  shift_dir_e        dir_q, dir_d;
  logic              fill_q, fill_d;
  logic              id_q, id_d;

  logic              grant_s;
  logic              accept_s;
  logic [K_W-1:0]    k_s;
  logic [DATA_W-1:0] next_acc_s;

  // Arbitration; ready is held low during reset so nothing is offered early.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_s = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    req_ready = 2'b00;
    if (rst_n && (state_q == IDLE) && req_valid[grant_s]) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
  end

  assign accept_s = |req_ready;

  // Step size for this cycle: STEP, or whatever is left if smaller.
  always_comb begin
    if (rem_q < STEP_AMT) begin
      k_s = rem_q[K_W-1:0];
    end else begin
      k_s = STEP_K;
    end
  end

  shift_step u_step (
    .acc_i      (acc_q),
    .k_i        (k_s),
    .dir_i      (dir_q),
    .fill_i     (fill_q),
    .next_acc_o (next_acc_s)
  );

  // Sequencer next-state logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    dir_d        = dir_q;
    fill_d       = fill_q;
    id_d         = id_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          acc_d  = req_data[grant_s];
          rem_d  = req_amt[grant_s];
          dir_d  = shift_dir_e'(req_dir[grant_s]);
          fill_d = req_dir[grant_s] & req_arith[grant_s] & req_data[grant_s][DATA_W-1];
          id_d   = grant_s;
          if (req_amt[grant_s] == {AMT_W{1'b0}}) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        acc_d = next_acc_s;
        rem_d = rem_q - AMT_W'(k_s);
        if (rem_d == {AMT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      acc_q        <= {DATA_W{1'b0}};
      rem_q        <= {AMT_W{1'b0}};
      dir_q        <= DIR_LEFT;
      fill_q       <= 1'b0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      fill_q       <= fill_d;
      id_q         <= id_d;
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = acc_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench: two scheduler instances (STEP=1 and STEP=4) against a shift reference model.
module tb_shift_sched;
  import shift_pkg::*;

  typedef struct {
    int          u;
    int          id;
    logic [31:0] data;
    logic [4:0]  amt;
    logic        dir;
    logic        arith;
    logic [31:0] exp_data;
    int          exp_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       rv   [2];
  logic [1:0]       rdy  [2];
  logic [1:0][31:0] rd   [2];
  logic [1:0][4:0]  ra   [2];
  logic [1:0]       rdir [2];
  logic [1:0]       rar  [2];
  logic             rspr [2];
  logic             rspv [2];
  logic [31:0]      rspd [2];
  logic             rspid[2];
  logic             bsy  [2];

  shift_sched #(.STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_data(rd[0]), .req_amt(ra[0]), .req_dir(rdir[0]), .req_arith(rar[0]),
    .rsp_valid(rspv[0]), .rsp_ready(rspr[0]), .rsp_data(rspd[0]),
    .rsp_id(rspid[0]), .busy(bsy[0])
  );

  shift_sched #(.STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_data(rd[1]), .req_amt(ra[1]), .req_dir(rdir[1]), .req_arith(rar[1]),
    .rsp_valid(rspv[1]), .rsp_ready(rspr[1]), .rsp_data(rspd[1]),
    .rsp_id(rspid[1]), .busy(bsy[1])
  );

  int errors = 0;
  int checks = 0;
  int last_g [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the whole shift done at once from the fill rules.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                            input logic dir, input logic arith);
    logic signed [31:0] s;
    if (!dir) return d << amt;
    if (arith) begin
      s = $signed(d);
      return 32'(s >>> amt);
    end
    return d >> amt;
  endfunction

  function automatic int exp_cycles(input int u, input int amt);
    int step;
    step = (u == 0) ? 1 : 4;
    return 1 + (amt + step - 1) / step;
  endfunction

  // Expects inputs already driven (after a negedge); returns at the negedge after the handshake.
  task automatic issue(input int u, input int exp_id, input int hold,
                       output int cyc, output logic [31:0] data, output logic id);
    int n;
    logic [1:0] e;
    e = (exp_id != 0) ? 2'b10 : 2'b01;
    n = 0;
    while (rdy[u] == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 32'(rdy[u]), 32'(e));
    @(posedge clk);
    @(negedge clk);
    rv[u] = rv[u] & ~e;
    cyc = 1;
    while (!rspv[u] && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_valid_seen", 32'(rspv[u]), 32'd1);
    chk("ready_while_busy", 32'(rdy[u]), 32'd0);
    data = rspd[u];
    id   = rspid[u];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rspv[u]), 32'd1);
      chk("hold_data", rspd[u], data);
      chk("hold_id", 32'(rspid[u]), 32'(id));
      chk("hold_ready", 32'(rdy[u]), 32'd0);
    end
    rspr[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rspr[u] = 1'b0;
    #1;
  endtask

  task automatic drive(input int u, input int id, input logic [31:0] d, input logic [4:0] a,
                       input logic dir, input logic ar);
    rd[u][id]   = d;
    ra[u][id]   = a;
    rdir[u][id] = dir;
    rar[u][id]  = ar;
  endtask

  vec_t vecs [6];

  initial begin
    int          cyc;
    logic [31:0] d;
    logic        id;
    int          seen;
    logic [1:0]  vm;
    int          g;

    vecs[0] = '{0, 0, 32'hF000_0000, 5'd4,  1'b1, 1'b1, 32'hFF00_0000, 5};
    vecs[1] = '{1, 1, 32'h0000_000F, 5'd28, 1'b0, 1'b0, 32'hF000_0000, 8};
    vecs[2] = '{0, 1, 32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678, 1};
    vecs[3] = '{0, 0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 32};
    vecs[4] = '{1, 0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, 9};
    vecs[5] = '{1, 1, 32'hFFFF_FFFF, 5'd5,  1'b0, 1'b0, 32'hFFFF_FFE0, 3};

    // Reset with random inputs applied.
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      rv[u] = 2'($urandom_range(0, 3));
      rd[u] = 64'({$urandom, $urandom});
      ra[u] = 10'($urandom);
      rdir[u] = 2'($urandom);
      rar[u] = 2'($urandom);
      rspr[u] = 1'($urandom);
      last_g[u] = 1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        chk("rst_valid", 32'(rspv[u]), 32'd0);
        chk("rst_busy", 32'(bsy[u]), 32'd0);
        chk("rst_ready", 32'(rdy[u]), 32'd0);
      end
    end
    for (int u = 0; u < 2; u++) begin
      rv[u] = 2'b00;
      rspr[u] = 1'b0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("idle_valid", 32'(rspv[u]), 32'd0);
      chk("idle_busy", 32'(bsy[u]), 32'd0);
      chk("idle_data", rspd[u], 32'd0);
      chk("idle_id", 32'(rspid[u]), 32'd0);
    end

    // Fairness: both valid continuously, amt 1.
    drive(0, 0, 32'h0000_0011, 5'd1, 1'b0, 1'b0);
    drive(0, 1, 32'h0000_0022, 5'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rv[0] = 2'b11;
      #1;
      issue(0, i % 2, 0, cyc, d, id);
      chk("fair_id", 32'(id), 32'(i % 2));
      chk("fair_data", d, (i % 2 == 0) ? 32'h0000_0022 : 32'h0000_0044);
      chk("fair_cyc", 32'(cyc), 32'd2);
    end
    last_g[0] = 1;

    // Zero amount with 3 cycles of backpressure while requester 1 waits.
    drive(0, 0, 32'h1234_5678, 5'd0, 1'b0, 1'b0);
    drive(0, 1, 32'h0000_0100, 5'd8, 1'b1, 1'b0);
    rv[0] = 2'b11;
    #1;
    issue(0, 0, 3, cyc, d, id);
    chk("zero_data", d, 32'h1234_5678);
    chk("zero_cyc", 32'(cyc), 32'd1);
    chk("waiting_ready", 32'(rdy[0]), 32'(2'b10));
    issue(0, 1, 0, cyc, d, id);
    chk("drain_data", d, 32'h0000_0001);
    chk("drain_id", 32'(id), 32'd1);
    last_g[0] = 1;

    // Directed vector table.
    foreach (vecs[v]) begin
      drive(vecs[v].u, vecs[v].id, vecs[v].data, vecs[v].amt, vecs[v].dir, vecs[v].arith);
      rv[vecs[v].u] = (vecs[v].id != 0) ? 2'b10 : 2'b01;
      #1;
      issue(vecs[v].u, vecs[v].id, 0, cyc, d, id);
      chk("vec_data", d, vecs[v].exp_data);
      chk("vec_id", 32'(id), 32'(vecs[v].id));
      chk("vec_cyc", 32'(cyc), 32'(vecs[v].exp_cyc));
      last_g[vecs[v].u] = vecs[v].id;
    end

    // Reset asserted in the third SHIFT cycle of an amt-31 command.
    @(negedge clk);
    drive(0, 0, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0);
    rv[0] = 2'b01;
    @(posedge clk);
    @(negedge clk);
    rv[0] = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bsy[0]), 32'd0);
    chk("midrst_valid", 32'(rspv[0]), 32'd0);
    chk("midrst_data", rspd[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_g[0] = 1;
    last_g[1] = 1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rspv[0] || bsy[0]) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    drive(0, 1, 32'h0000_00F0, 5'd3, 1'b1, 1'b0);
    rv[0] = 2'b10;
    #1;
    issue(0, 1, 0, cyc, d, id);
    chk("post_rst_data", d, 32'h0000_001E);
    chk("post_rst_cyc", 32'(cyc), 32'd4);
    last_g[0] = 1;

    // Random commands against the reference model.
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 30; n++) begin
        for (int r = 0; r < 2; r++) begin
          drive(u, r, $urandom,
                ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31)
                                             : 5'($urandom_range(0, 31)),
                1'($urandom), 1'($urandom));
        end
        vm = 2'($urandom_range(1, 3));
        if (vm == 2'b11) g = 1 - last_g[u];
        else g = vm[1] ? 1 : 0;
        rv[u] = vm;
        #1;
        issue(u, g, $urandom_range(0, 3), cyc, d, id);
        chk("rand_data", d, ref_shift(rd[u][g], int'(ra[u][g]), rdir[u][g], rar[u][g]));
        chk("rand_id", 32'(id), 32'(g));
        chk("rand_cyc", 32'(cyc), 32'(exp_cycles(u, int'(ra[u][g]))));
        last_g[u] = g;
        rv[u] = 2'b00;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
